// File: rtl/universal_shift_register.sv
// WIDTH-bit register with parallel load and a counted, mode-selected
// multi-step shift sequence, using a busy/done handshake (IDLE -> SHIFT -> DONE).
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [AMT_W-1:0] WMAX = AMT_W'(WIDTH);

  state_t           state, state_nx;
  logic [2:0]       mode_q, mode_nx;
  logic [AMT_W-1:0] cnt, cnt_nx, amt_sat;
  logic [WIDTH-1:0] data_nx, step_q;
  logic             ser_nx, step_so;

  assign amt_sat = (amount > WMAX) ? WMAX : amount;
  assign busy    = (state == SHIFT);
  assign done    = (state == DONE);

  // One single-bit step of the latched mode; reserved mode holds everything.
  always_comb begin
    step_q  = data_out;
    step_so = ser_out;
    case (mode_q)
      3'b000: begin step_q = {data_out[WIDTH-2:0], 1'b0};               step_so = data_out[WIDTH-1]; end
      3'b001: begin step_q = {1'b0, data_out[WIDTH-1:1]};               step_so = data_out[0];       end
      3'b010: begin step_q = {data_out[WIDTH-1], data_out[WIDTH-1:1]};  step_so = data_out[0];       end
      3'b011: begin step_q = {data_out[WIDTH-2:0], data_out[WIDTH-1]};  step_so = data_out[WIDTH-1]; end
      3'b100: begin step_q = {data_out[0], data_out[WIDTH-1:1]};        step_so = data_out[0];       end
      3'b101: begin step_q = {data_out[WIDTH-2:0], ser_in};             step_so = data_out[WIDTH-1]; end
      3'b110: begin step_q = {ser_in, data_out[WIDTH-1:1]};             step_so = data_out[0];       end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    mode_nx  = mode_q;
    cnt_nx   = cnt;
    data_nx  = data_out;
    ser_nx   = ser_out;
    case (state)
      IDLE: begin
        if (load) begin
          data_nx = data_in;
        end else if (start) begin
          mode_nx  = mode;
          cnt_nx   = amt_sat;
          state_nx = (amt_sat == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_nx = step_q;
        ser_nx  = step_so;
        cnt_nx  = cnt - 1'b1;
        if (cnt == AMT_W'(1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mode_q   <= '0;
      cnt      <= '0;
      data_out <= '0;
      ser_out  <= 1'b0;
    end else begin
      state    <= state_nx;
      mode_q   <= mode_nx;
      cnt      <= cnt_nx;
      data_out <= data_nx;
      ser_out  <= ser_nx;
    end
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised successor to the team's 8-bit left/right shift register. Holds a WIDTH-bit word and supports parallel load and a multi-step shift sequence. Each sequence runs one of seven modes (logical, arithmetic, rotate, serial-in) for a programmable number of single-bit steps. A busy/done handshake lets a controlling FSM or bench issue a shift command and wait for it to complete.

Parameters:
WIDTH, 8, register width in bits (>= 2)
AMT_W, 4, width of the shift-amount port; 2**AMT_W must be > WIDTH

Ports:
clk       input   1        single clock, all state changes on rising edge
reset     input   1        synchronous, active-high reset
load      input   1        parallel load of data_in (accepted in IDLE only)
data_in   input   WIDTH    parallel load value
start     input   1        begin shift sequence (accepted in IDLE only)
mode      input   3        shift mode, latched on accepted start
amount    input   AMT_W    number of steps, latched on accepted start
ser_in    input   1        serial input bit, sampled on every SHIFT-state edge
data_out  output  WIDTH    register contents
ser_out   output  1        last bit shifted out of the register
busy      output  1        high while in SHIFT state
done      output  1        one-cycle completion pulse (DONE state)

Behaviour:
- Reset (sync, active-high, highest priority, valid in any state including mid-sequence):
  - data_out = 0, ser_out = 0, busy = 0, done = 0
  - state = IDLE; latched mode and count cleared
- States: IDLE, SHIFT, DONE. Outputs are decoded from state: busy = (state == SHIFT), done = (state == DONE).
- IDLE:
  - load = 1: data_out <= data_in; state stays IDLE.
  - load = 1 and start = 1 in the same cycle: load wins, start is dropped.
  - start = 1 (load = 0): latch mode; latch cnt = min(amount, WIDTH).
    - cnt == 0: go to DONE; data unchanged.
    - otherwise: go to SHIFT; no data change on this edge.
- SHIFT: each edge performs one step, decrements cnt, and updates ser_out with the bit leaving the register.
  - When cnt reaches 0 on that edge, go to DONE.
  - An N-step sequence holds busy for exactly N cycles.
- Step definitions (q = data_out):
  - 000 SLL: q <= {q[W-2:0], 0}; ser_out <= q[W-1]
  - 001 SRL: q <= {0, q[W-1:1]}; ser_out <= q[0]
  - 010 SRA: q <= {q[W-1], q[W-1:1]}; ser_out <= q[0]
  - 011 ROL: q <= {q[W-2:0], q[W-1]}; ser_out <= q[W-1]
  - 100 ROR: q <= {q[0], q[W-1:1]}; ser_out <= q[0]
  - 101 SIL: q <= {q[W-2:0], ser_in}; ser_out <= q[W-1]
  - 110 SIR: q <= {ser_in, q[W-1:1]}; ser_out <= q[0]
  - 111 reserved: q and ser_out hold; the sequence still runs for cnt cycles.
- DONE: done = 1 for exactly one cycle, then IDLE on the next edge.
- Inputs ignored outside IDLE: start and load asserted in SHIFT or DONE have no effect and are not queued.
- Mid-sequence inputs: changes to mode and amount have no effect during a sequence; ser_in is the only input sampled in SHIFT.
- ser_out holds its value between sequences; load does not change it.
- Total latency, start edge to done high: cnt + 1 edges (1 edge when cnt == 0).

Test Plan:
1. Reset: assert reset for 2 cycles -> data_out = 8'h00, ser_out = 0, busy = 0, done = 0.
2. Load 8'hAA, then start mode = 000, amount = 3 -> busy high for 3 cycles, then done pulse for 1 cycle; data_out = 8'h50, ser_out = 1.
3. Load 8'h96, then start mode = 010, amount = 2 -> data_out = 8'hE5, ser_out = 1. Repeat with mode = 001 from 8'h96 -> data_out = 8'h25.
4. Load 8'hA5, then start mode = 011, amount = 8 -> data_out = 8'hA5, busy for 8 cycles. Repeat with amount = 12 -> saturates: busy for 8 cycles, data_out = 8'hA5.
5. Load 8'h00, then start mode = 110, amount = 4, ser_in = 1,0,1,1 on successive SHIFT cycles -> data_out = 8'hD0, ser_out = 0.
6. Corner cases:
   - amount = 0 -> done pulses on the cycle after start; busy never rises.
   - start during busy -> ignored; sequence length unchanged.
   - load + start together -> load applied, no sequence starts.
   - reset asserted at step 2 of 5 -> all outputs 0 next cycle; a following start/load works normally.
